// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if
//   Video-memory port between the arbiter and the SDRAM controller front end.
//   The requester holds mem_req, with stable mem_we/mem_addr/mem_wdata, until
//   the controller answers with a one-cycle mem_ack.
//
// Signals:
//   mem_req    request, held until mem_ack
//   mem_we     1 = write, 0 = read; valid while mem_req is high
//   mem_addr   memory address
//   mem_wdata  write data
//   mem_ack    one-cycle completion pulse from the controller
//   mem_rdata  read data, valid with mem_ack
//
// Modports:
//   master  arbiter side (drives the request)
//   slave   memory controller side (drives ack and read data)
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares the single video-memory port between the VGA line fetcher (reads)
//   and the Z80 write path (writes). CPU writes land in a one-entry posted
//   write buffer; while it is full cpu_busy stalls the Z80 through WAIT.
//   Video has priority over the CPU.
//
// Build option:
//   VRAM_ARB_STARVE_GUARD_EN  when defined, a run counter limits video to
//                             MAX_VID_RUN consecutive grants while a CPU write
//                             is pending, after which the CPU is served.
//                             When undefined, strict video priority.
//
// Ports:
//   clk25     25 MHz system clock, rising edge
//   RESET     asynchronous, active-low reset
//   vid_req   video read request (level, held until vid_ack)
//   vid_addr  video read address
//   vid_ack   one-cycle pulse, vid_data valid
//   vid_data  read data registered from mem_rdata
//   cpu_wr    one-cycle write strobe (synchronous to clk25)
//   cpu_addr  write address, sampled with cpu_wr
//   cpu_data  write data, sampled with cpu_wr
//   cpu_busy  posted-write buffer full
//   cpu_ovf   sticky: a write arrived while the buffer was full
//   mem       memory port (vram_arbiter_if.master)
module vram_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int MAX_VID_RUN = 4
) (
  input  logic              clk25,
  input  logic              RESET,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_busy,
  output logic              cpu_ovf,
  vram_arbiter_if.master    mem
);

  if (MAX_VID_RUN < 1 || MAX_VID_RUN > 15) begin : g_bad_max_vid_run
    $error("vram_arbiter: MAX_VID_RUN must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    VID,
    CPU
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              grant_vid;
  logic              grant_cpu;
  logic              cpu_done;

  // The CPU write completes in the cycle its ack arrives; a new strobe in
  // that same cycle may reuse the slot instead of overflowing.
  assign cpu_done = (state == CPU) && mem.mem_ack;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] RUN_LIMIT = 4'(MAX_VID_RUN);

  logic [3:0] run_cnt;
  logic       force_cpu;

  // Once video has taken RUN_LIMIT grants past a pending write, the CPU
  // wins the next IDLE cycle even against an active vid_req.
  always_comb begin
    force_cpu = cpu_busy && (run_cnt == RUN_LIMIT);
    grant_cpu = cpu_busy && (!vid_req || force_cpu);
    grant_vid = vid_req && !vid_ack && !grant_cpu;
  end

  // Count only video grants that overtake a pending write.
  always_ff @(posedge clk25 or negedge RESET) begin
    if (!RESET) begin
      run_cnt <= 4'd0;
    end else if (!cpu_busy) begin
      run_cnt <= 4'd0;
    end else if (state == IDLE && grant_cpu) begin
      run_cnt <= 4'd0;
    end else if (state == IDLE && grant_vid) begin
      run_cnt <= run_cnt + 4'd1;
    end
  end
`else
  // A vid_req still high during its own vid_ack cycle is the old request,
  // so neither side is granted in that cycle.
  always_comb begin
    grant_vid = vid_req && !vid_ack;
    grant_cpu = cpu_busy && !vid_req;
  end
`endif

  // Arbitration FSM and posted-write buffer. Every output is a register.
  always_ff @(posedge clk25 or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      vid_ack       <= 1'b0;
      vid_data      <= '0;
      cpu_busy      <= 1'b0;
      cpu_ovf       <= 1'b0;
      buf_addr      <= '0;
      buf_data      <= '0;
    end else begin
      vid_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state         <= CPU;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b1;
            mem.mem_addr  <= buf_addr;
            mem.mem_wdata <= buf_data;
          end else if (grant_vid) begin
            state        <= VID;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= vid_addr;
          end
        end
        VID: begin
          if (mem.mem_ack) begin
            state       <= IDLE;
            mem.mem_req <= 1'b0;
            vid_data    <= mem.mem_rdata;
            vid_ack     <= 1'b1;
          end
        end
        CPU: begin
          if (mem.mem_ack) begin
            state       <= IDLE;
            mem.mem_req <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          mem.mem_req <= 1'b0;
        end
      endcase

      if (cpu_wr) begin
        if (!cpu_busy || cpu_done) begin
          buf_addr <= cpu_addr;
          buf_data <= cpu_data;
          cpu_busy <= 1'b1;
        end else begin
          cpu_ovf <= 1'b1;
        end
      end else if (cpu_done) begin
        cpu_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Directed testbench for vram_arbiter. Inputs are driven and outputs are
//   sampled on the falling edge of clk25; the memory controller is modelled
//   by the test tasks pulsing mem_ack directly on the interface.
module tb_vram_arbiter;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk25 = 1'b0;
  logic        RESET = 1'b0;
  logic        vid_req = 1'b0;
  logic [15:0] vid_addr = '0;
  logic        vid_ack;
  logic [7:0]  vid_data;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        cpu_busy;
  logic        cpu_ovf;

  int asserts  = 0;
  int failures = 0;

  vram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) mem_bus ();

  vram_arbiter #(
    .ADDR_W      (16),
    .DATA_W      (8),
    .MAX_VID_RUN (4)
  ) dut (
    .clk25    (clk25),
    .RESET    (RESET),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_ack  (vid_ack),
    .vid_data (vid_data),
    .cpu_wr   (cpu_wr),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_busy (cpu_busy),
    .cpu_ovf  (cpu_ovf),
    .mem      (mem_bus)
  );

  always #20 clk25 = ~clk25;

  task automatic tick();
    @(negedge clk25);
  endtask

  // Waits (bounded) at falling edges until mem_req is high.
  task automatic wait_mem_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_bus.mem_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int rises;
    RESET = 1'b0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    repeat (2) tick();
    asserts++; if (mem_bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem_req: got %b expected 0", mem_bus.mem_req); end
    asserts++; if (mem_bus.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem_we: got %b expected 0", mem_bus.mem_we); end
    asserts++; if (mem_bus.mem_addr !== 16'h0000) begin failures++; $display("[TB] FAIL rst_mem_addr: got %h expected 0000", mem_bus.mem_addr); end
    asserts++; if (vid_ack !== 1'b0) begin failures++; $display("[TB] FAIL rst_vid_ack: got %b expected 0", vid_ack); end
    asserts++; if (vid_data !== 8'h00) begin failures++; $display("[TB] FAIL rst_vid_data: got %h expected 00", vid_data); end
    asserts++; if (cpu_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_cpu_busy: got %b expected 0", cpu_busy); end
    asserts++; if (cpu_ovf !== 1'b0) begin failures++; $display("[TB] FAIL rst_cpu_ovf: got %b expected 0", cpu_ovf); end
    RESET = 1'b1;
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_bus.mem_req !== 1'b0 || vid_ack !== 1'b0 || cpu_busy !== 1'b0) rises++;
    end
    asserts++; if (rises !== 0) begin failures++; $display("[TB] FAIL idle_quiet: got %0d active cycles expected 0", rises); end
  endtask

  task automatic test_cpu_write();
    cpu_addr = 16'h4000;
    cpu_data = 8'h42;
    cpu_wr   = 1'b1;
    tick();
    cpu_wr = 1'b0;
    asserts++; if (cpu_busy !== 1'b1) begin failures++; $display("[TB] FAIL wr_busy_rise: got %b expected 1", cpu_busy); end
    asserts++; if (mem_bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL wr_req_early: got %b expected 0", mem_bus.mem_req); end
    tick();
    asserts++; if (mem_bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL wr_req: got %b expected 1", mem_bus.mem_req); end
    asserts++; if (mem_bus.mem_we !== 1'b1) begin failures++; $display("[TB] FAIL wr_we: got %b expected 1", mem_bus.mem_we); end
    asserts++; if (mem_bus.mem_addr !== 16'h4000) begin failures++; $display("[TB] FAIL wr_addr: got %h expected 4000", mem_bus.mem_addr); end
    asserts++; if (mem_bus.mem_wdata !== 8'h42) begin failures++; $display("[TB] FAIL wr_wdata: got %h expected 42", mem_bus.mem_wdata); end
    repeat (2) tick();
    asserts++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h4000) begin failures++; $display("[TB] FAIL wr_req_held: got req=%b addr=%h expected req=1 addr=4000", mem_bus.mem_req, mem_bus.mem_addr); end
    tick();
    asserts++; if (cpu_busy !== 1'b1) begin failures++; $display("[TB] FAIL wr_busy_held: got %b expected 1", cpu_busy); end
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    asserts++; if (mem_bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL wr_req_drop: got %b expected 0", mem_bus.mem_req); end
    asserts++; if (cpu_busy !== 1'b0) begin failures++; $display("[TB] FAIL wr_busy_fall: got %b expected 0", cpu_busy); end
    tick();
    asserts++; if (mem_bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL wr_no_reissue: got %b expected 0", mem_bus.mem_req); end
  endtask

  task automatic test_video_read();
    vid_addr = 16'h5800;
    vid_req  = 1'b1;
    tick();
    asserts++; if (mem_bus.mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rd_req: got %b expected 1", mem_bus.mem_req); end
    asserts++; if (mem_bus.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rd_we: got %b expected 0", mem_bus.mem_we); end
    asserts++; if (mem_bus.mem_addr !== 16'h5800) begin failures++; $display("[TB] FAIL rd_addr: got %h expected 5800", mem_bus.mem_addr); end
    tick();
    asserts++; if (vid_ack !== 1'b0) begin failures++; $display("[TB] FAIL rd_ack_early: got %b expected 0", vid_ack); end
    mem_bus.mem_rdata = 8'hA5;
    mem_bus.mem_ack   = 1'b1;
    tick();
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 8'h00;
    asserts++; if (vid_ack !== 1'b1) begin failures++; $display("[TB] FAIL rd_ack: got %b expected 1", vid_ack); end
    asserts++; if (vid_data !== 8'hA5) begin failures++; $display("[TB] FAIL rd_data: got %h expected a5", vid_data); end
    vid_req = 1'b0;
    tick();
    asserts++; if (vid_ack !== 1'b0) begin failures++; $display("[TB] FAIL rd_ack_pulse: got %b expected 0", vid_ack); end
    asserts++; if (mem_bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rd_idle: got %b expected 0", mem_bus.mem_req); end
    asserts++; if (vid_data !== 8'hA5) begin failures++; $display("[TB] FAIL rd_data_hold: got %h expected a5", vid_data); end
  endtask

  task automatic test_overflow();
    asserts++; if (cpu_ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear: got %b expected 0", cpu_ovf); end
    cpu_addr = 16'h4000;
    cpu_data = 8'h33;
    cpu_wr   = 1'b1;
    tick();
    cpu_addr = 16'h4002;
    cpu_data = 8'h77;
    asserts++; if (cpu_busy !== 1'b1 || cpu_ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_first: got busy=%b ovf=%b expected busy=1 ovf=0", cpu_busy, cpu_ovf); end
    tick();
    asserts++; if (cpu_ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set: got %b expected 1", cpu_ovf); end
    asserts++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h4000 || mem_bus.mem_wdata !== 8'h33) begin failures++; $display("[TB] FAIL ovf_kept: got req=%b addr=%h data=%h expected req=1 addr=4000 data=33", mem_bus.mem_req, mem_bus.mem_addr, mem_bus.mem_wdata); end
    cpu_addr        = 16'h4001;
    cpu_data        = 8'h55;
    mem_bus.mem_ack = 1'b1;
    tick();
    cpu_wr          = 1'b0;
    mem_bus.mem_ack = 1'b0;
    asserts++; if (cpu_busy !== 1'b1) begin failures++; $display("[TB] FAIL ovf_reload_busy: got %b expected 1", cpu_busy); end
    asserts++; if (mem_bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL ovf_gap: got %b expected 0", mem_bus.mem_req); end
    tick();
    asserts++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b1 || mem_bus.mem_addr !== 16'h4001 || mem_bus.mem_wdata !== 8'h55) begin failures++; $display("[TB] FAIL ovf_reload_wr: got req=%b we=%b addr=%h data=%h expected 1 1 4001 55", mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata); end
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    asserts++; if (cpu_busy !== 1'b0) begin failures++; $display("[TB] FAIL ovf_drain: got %b expected 0", cpu_busy); end
    asserts++; if (cpu_ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky: got %b expected 1", cpu_ovf); end
  endtask

  task automatic test_starvation();
    bit          seen;
    logic        exp_we;
    logic [15:0] exp_addr;
    vid_addr = 16'h5900;
    vid_req  = 1'b1;
    tick();
    asserts++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL stv_first_rd: got req=%b we=%b expected req=1 we=0", mem_bus.mem_req, mem_bus.mem_we); end
    cpu_addr = 16'h4100;
    cpu_data = 8'h99;
    cpu_wr   = 1'b1;
    tick();
    cpu_wr = 1'b0;
    asserts++; if (cpu_busy !== 1'b1) begin failures++; $display("[TB] FAIL stv_pending: got %b expected 1", cpu_busy); end
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_we   = GUARD && (k == 4);
      exp_addr = exp_we ? 16'h4100 : 16'h5900;
      wait_mem_req(seen);
      asserts++; if (!seen) begin failures++; $display("[TB] FAIL stv_grant%0d: got no mem_req expected mem_req within 20 cycles", k); end
      asserts++; if (mem_bus.mem_we !== exp_we || mem_bus.mem_addr !== exp_addr) begin failures++; $display("[TB] FAIL stv_order%0d: got we=%b addr=%h expected we=%b addr=%h", k, mem_bus.mem_we, mem_bus.mem_addr, exp_we, exp_addr); end
      mem_bus.mem_ack = 1'b1;
      tick();
      mem_bus.mem_ack = 1'b0;
    end
    asserts++; if (cpu_busy !== !GUARD) begin failures++; $display("[TB] FAIL stv_busy: got %b expected %b", cpu_busy, !GUARD); end
    vid_req = 1'b0;
    if (!GUARD) begin
      wait_mem_req(seen);
      asserts++; if (!seen || mem_bus.mem_we !== 1'b1 || mem_bus.mem_addr !== 16'h4100 || mem_bus.mem_wdata !== 8'h99) begin failures++; $display("[TB] FAIL stv_late_wr: got seen=%b we=%b addr=%h data=%h expected 1 1 4100 99", seen, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata); end
      mem_bus.mem_ack = 1'b1;
      tick();
      mem_bus.mem_ack = 1'b0;
    end
    tick();
    asserts++; if (cpu_busy !== 1'b0 || mem_bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL stv_end: got busy=%b req=%b expected 0 0", cpu_busy, mem_bus.mem_req); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int rises;
    cpu_addr = 16'h4200;
    cpu_data = 8'hAA;
    cpu_wr   = 1'b1;
    tick();
    cpu_wr = 1'b0;
    wait_mem_req(seen);
    asserts++; if (!seen || mem_bus.mem_we !== 1'b1) begin failures++; $display("[TB] FAIL mid_wr: got seen=%b we=%b expected 1 1", seen, mem_bus.mem_we); end
    #5 RESET = 1'b0;
    #1;
    asserts++; if (mem_bus.mem_req !== 1'b0) begin failures++; $display("[TB] FAIL mid_req_drop: got %b expected 0", mem_bus.mem_req); end
    asserts++; if (cpu_busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy_drop: got %b expected 0", cpu_busy); end
    asserts++; if (cpu_ovf !== 1'b0) begin failures++; $display("[TB] FAIL mid_ovf_clear: got %b expected 0", cpu_ovf); end
    tick();
    RESET = 1'b1;
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_bus.mem_req !== 1'b0 || cpu_busy !== 1'b0) rises++;
    end
    asserts++; if (rises !== 0) begin failures++; $display("[TB] FAIL mid_no_reissue: got %0d active cycles expected 0", rises); end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_video_read();
    test_overflow();
    test_starvation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
